// File: rtl/sd_rx_fifo_pack_if.sv
// Bus between the SD receive FIFO and its neighbours: sample input, pop side and status.
// master drives samples/control and observes status; slave is the FIFO itself.
interface sd_rx_fifo_pack_if #(
  parameter int IN_W  = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [IN_W-1:0] d;
  logic            wr;
  logic            wlast;
  logic            flush;
  logic            rd;
  logic [31:0]     q;
  logic            empty;
  logic            full;
  logic            almost_full;
  logic [AW:0]     count;
  logic            ovf;

  modport master (
    output d, wr, wlast, flush, rd,
    input  q, empty, full, almost_full, count, ovf
  );

  modport slave (
    input  d, wr, wlast, flush, rd,
    output q, empty, full, almost_full, count, ovf
  );
endinterface

// File: rtl/sd_rx_fifo_pack.sv
// SD receive FIFO: packs IN_W-bit samples into 32-bit words and buffers DEPTH words.
// Define SD_RX_FIFO_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module sd_rx_fifo_pack #(
  parameter int IN_W      = 4,
  parameter int DEPTH     = 8,
  parameter int BIG_END   = 0,
  parameter int AFULL_THR = DEPTH - 1
) (
  input logic              clk,
  input logic              rst,
  sd_rx_fifo_pack_if.slave bus
);
  localparam int L  = 32 / IN_W;
  localparam int LW = $clog2(L);
  localparam int AW = $clog2(DEPTH);

  logic [LW-1:0] ln;
  logic [LW-1:0] lane;
  logic [31:0]   pack;
  logic [31:0]   merged;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   cnt;
  logic          commit;
  logic          pop;
  logic          accept;
  logic [31:0]   mem [DEPTH];

  assign lane = (BIG_END != 0) ? LW'(L - 1) - ln : ln;

  // Lanes above the current one are still zero in pack, which gives the wlast padding for free.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    merged = pack;
    for (int i = 0; i < L; i++) begin
      if (lane == LW'(i)) merged[i*IN_W +: IN_W] = bus.d;
    end
  end

  assign cnt    = wr_ptr - rd_ptr;
  assign commit = bus.wr & (bus.wlast | (ln == LW'(L - 1)));
  assign pop    = bus.rd & ~bus.empty;
  assign accept = commit & (~bus.full | pop);

  assign bus.count       = cnt;
  assign bus.empty       = (cnt == '0);
  assign bus.full        = (cnt == (AW+1)'(DEPTH));
  assign bus.almost_full = (cnt >= (AW+1)'(AFULL_THR));
  assign bus.q           = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      ln     <= '0;
      pack   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (bus.wr) begin
        if (commit) begin
          ln   <= '0;
          pack <= '0;
        end else begin
          ln   <= ln + LW'(1);
          pack <= merged;
        end
      end
    end
  end

  // NOTE: the word storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (accept && !rst && !bus.flush) mem[wr_ptr[AW-1:0]] <= merged;
  end

`ifdef SD_RX_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) ovf_q <= 1'b0;
    else if (commit && !accept) ovf_q <= 1'b1;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_sd_rx_fifo_pack.sv
// Self-checking bench: LE and BE nibble FIFOs fed in lockstep against a queue model,
// plus a 1-bit-wide instance for the serial and almost-full corner cases.
module tb_sd_rx_fifo_pack;
  localparam int DEPTH = 4;
`ifdef SD_RX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_rx_fifo_pack_if #(.IN_W(4), .DEPTH(DEPTH)) ia ();
  sd_rx_fifo_pack_if #(.IN_W(4), .DEPTH(DEPTH)) ib ();
  sd_rx_fifo_pack_if #(.IN_W(1), .DEPTH(DEPTH)) ic ();

  sd_rx_fifo_pack #(.IN_W(4), .DEPTH(DEPTH), .BIG_END(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  sd_rx_fifo_pack #(.IN_W(4), .DEPTH(DEPTH), .BIG_END(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  sd_rx_fifo_pack #(.IN_W(1), .DEPTH(DEPTH), .BIG_END(0), .AFULL_THR(3)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected words for the LE and BE instances plus the partial-word model.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] wa, wb;
  int          mlane;
  bit          movf;

  typedef struct {
    int              n;
    logic [7:0][3:0] s;
    logic            last;
    logic [31:0]     exp_le;
    logic [31:0]     exp_be;
  } vec_t;
  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.d = '0; ia.wr = 0; ia.wlast = 0; ia.flush = 0; ia.rd = 0;
    ib.d = '0; ib.wr = 0; ib.wlast = 0; ib.flush = 0; ib.rd = 0;
    ic.d = '0; ic.wr = 0; ic.wlast = 0; ic.flush = 0; ic.rd = 0;
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    wa = '0; wb = '0; mlane = 0; movf = 0;
  endtask

  task automatic check_flags_ab();
    check("count_le", 32'(ia.count), qa.size());
    check("count_be", 32'(ib.count), qb.size());
    check("empty", 32'(ia.empty), 32'(qa.size() == 0));
    check("full", 32'(ia.full), 32'(qa.size() == DEPTH));
    check("almost_full", 32'(ia.almost_full), 32'(qa.size() >= DEPTH - 1));
    check("ovf", 32'(ia.ovf), 32'(movf));
  endtask

  // One cycle on the A/B pair with optional sample and optional pop.
  task automatic step_ab(input bit w, input logic [3:0] s, input bit last, input bit r);
    bit com, acc, popm;
    ia.d = s; ia.wr = w; ia.wlast = last; ia.rd = r;
    ib.d = s; ib.wr = w; ib.wlast = last; ib.rd = r;
    popm = r && (qa.size() > 0);
    if (popm) begin
      check("pop_q_le", ia.q, qa[0]);
      check("pop_q_be", ib.q, qb[0]);
    end
    com = w && (last || mlane == 7);
    acc = com && ((qa.size() < DEPTH) || popm);
    if (w) begin
      wa = wa | (32'(s) << (4 * mlane));
      wb = wb | (32'(s) << (4 * (7 - mlane)));
    end
    tick();
    if (popm) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    if (w) begin
      if (com) begin
        if (acc) begin
          qa.push_back(wa);
          qb.push_back(wb);
        end else if (OVF_EN) begin
          movf = 1;
        end
        wa = '0; wb = '0; mlane = 0;
      end else begin
        mlane++;
      end
    end
    idle_all();
    check_flags_ab();
  endtask

  task automatic read_ab();
    step_ab(0, 4'h0, 0, 1);
  endtask

  task automatic send_word_ab(input logic [31:0] w, input bit r_last);
    for (int i = 0; i < 8; i++) step_ab(1, w[4*i +: 4], 0, (i == 7) && r_last);
  endtask

  task automatic flush_ab();
    ia.flush = 1; ia.wr = 1; ia.rd = 1; ia.d = 4'h9;
    ib.flush = 1; ib.wr = 1; ib.rd = 1; ib.d = 4'h9;
    tick();
    idle_all();
    model_clear();
    check_flags_ab();
  endtask

  task automatic step_c(input logic b);
    ic.d = b; ic.wr = 1;
    tick();
    ic.wr = 0;
  endtask

  task automatic send_word_c(input logic [31:0] w);
    for (int i = 0; i < 32; i++) step_c(w[i]);
  endtask

  initial begin
    vt[0] = '{n: 8, s: 32'h87654321, last: 0, exp_le: 32'h87654321, exp_be: 32'h12345678};
    vt[1] = '{n: 3, s: 32'h00000CBA, last: 1, exp_le: 32'h00000CBA, exp_be: 32'hABC00000};
    vt[2] = '{n: 8, s: 32'h89ABCDEF, last: 0, exp_le: 32'h89ABCDEF, exp_be: 32'hFEDCBA98};
    vt[3] = '{n: 1, s: 32'h00000005, last: 1, exp_le: 32'h00000005, exp_be: 32'h50000000};
    vt[4] = '{n: 7, s: 32'h07654321, last: 1, exp_le: 32'h07654321, exp_be: 32'h12345670};

    idle_all();
    model_clear();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check_flags_ab();
    check("rst_empty_c", 32'(ic.empty), 1);
    check("rst_count_c", 32'(ic.count), 0);

    // Packing and lane order, including wlast padding and lane restart.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < vt[k].n; i++)
        step_ab(1, vt[k].s[i], (i == vt[k].n - 1) && vt[k].last, 0);
      check("tbl_count", 32'(ia.count), 1);
      check("tbl_q_le", ia.q, vt[k].exp_le);
      check("tbl_q_be", ib.q, vt[k].exp_be);
      read_ab();
    end

    // Fill, overflow drop, in-order drain, rd while empty, flush clears ovf.
    for (int k = 0; k < DEPTH; k++) send_word_ab(32'hA0000000 + k * 32'h01010101, 0);
    check("fill_full", 32'(ia.full), 1);
    check("fill_count", 32'(ia.count), DEPTH);
    send_word_ab(32'h5A5A5A5A, 0);
    check("drop_ovf", 32'(ia.ovf), 32'(OVF_EN));
    for (int k = 0; k < DEPTH; k++) read_ab();
    check("ovf_sticky", 32'(ia.ovf), 32'(OVF_EN));
    read_ab();
    flush_ab();

    // Commit while full with a same-cycle pop, then a stream across pointer wrap.
    for (int k = 0; k < DEPTH; k++) send_word_ab(32'hC0DE0000 + 32'(k), 0);
    send_word_ab(32'hBEEF0001, 1);
    check("full_pop_count", 32'(ia.count), DEPTH);
    check("full_pop_ovf", 32'(ia.ovf), 0);
    for (int k = 0; k < 12; k++)
      for (int i = 0; i < 8; i++)
        step_ab(1, 4'(k + i * 3), (k % 5 == 4) && (i == 5), (i % 3 == 0));
    for (int k = 0; k < DEPTH + 1; k++) read_ab();

    // Flush mid-word with rd asserted, then a clean word from lane 0.
    send_word_ab(32'h11111111, 0);
    send_word_ab(32'h22222222, 0);
    for (int i = 0; i < 5; i++) step_ab(1, 4'hE, 0, 0);
    flush_ab();
    for (int i = 0; i < 8; i++) step_ab(1, 4'(i + 1), 0, 0);
    check("post_flush_q", ia.q, 32'h87654321);
    read_ab();

    // Serial lane: alternating bits and almost_full threshold.
    send_word_c(32'h55555555);
    check("c_af_1", 32'(ic.almost_full), 0);
    send_word_c(32'hDEADBEEF);
    check("c_af_2", 32'(ic.almost_full), 0);
    send_word_c(32'h0F0F00FF);
    check("c_af_3", 32'(ic.almost_full), 1);
    check("c_count_3", 32'(ic.count), 3);
    check("c_q_alt", ic.q, 32'h55555555);
    ic.rd = 1;
    tick();
    ic.rd = 0;
    check("c_af_pop", 32'(ic.almost_full), 0);
    check("c_q_next", ic.q, 32'hDEADBEEF);

    // Reset mid-word: partial samples are lost and the next sample is lane 0.
    for (int i = 0; i < 5; i++) step_c(1'b1);
    rst = 1;
    tick();
    rst = 0;
    check("c_rst_count", 32'(ic.count), 0);
    send_word_c(32'h12345678);
    check("c_rst_q", ic.q, 32'h12345678);
    check("c_rst_count1", 32'(ic.count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
